// File: rtl/down_counter_4bit.sv
// Loadable synchronous down counter with a registered one-cycle borrow pulse on wrap from zero.
// Optional macro DOWN_COUNTER_AUTO_RELOAD_EN: the wrap reloads the last loaded value instead of all-ones.
module down_counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow
);

    logic [WIDTH-1:0] r_count;
    logic             r_borrow;
    logic [WIDTH-1:0] w_wrap_val;
    logic             w_at_zero;

    assign w_at_zero = (r_count == '0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload_val;

    // Reload value follows only load and reset, never the decrement path.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_reload_val <= '0;
        end else if (load) begin
            r_reload_val <= load_data;
        end
    end

    assign w_wrap_val = r_reload_val;
`else
    assign w_wrap_val = '1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_borrow <= 1'b0;
        end else if (load) begin
            r_count  <= load_data;
            r_borrow <= 1'b0;
        end else if (enable) begin
            if (w_at_zero) begin
                r_count  <= w_wrap_val;
                r_borrow <= 1'b1;
            end else begin
                r_count  <= r_count - WIDTH'(1);
                r_borrow <= 1'b0;
            end
        end else begin
            r_borrow <= 1'b0;
        end
    end

    assign count  = r_count;
    assign zero   = w_at_zero;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_down_counter_4bit.sv
// Scoreboard bench for down_counter_4bit; expectations come from a reference model and fixed tables.
// Works in both builds of DOWN_COUNTER_AUTO_RELOAD_EN.
module tb_down_counter_4bit;

    logic       clk = 1'b0;
    logic       resetN;
    logic       load;
    logic [3:0] loadData;
    logic       enable;
    logic [3:0] count;
    logic       zero;
    logic       borrow;

    // Expected {count, zero, borrow} pushed per driven edge.
    logic [5:0] sbq[$];
    logic [5:0] exp;
    logic [3:0] mCount;
    logic [3:0] mReload;
    logic       mBorrow;
    int         nCompared = 0;
    int         nMismatched = 0;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    down_counter_4bit #(.WIDTH(4)) dut (
        .clk(clk),
        .reset_n(resetN),
        .load(load),
        .load_data(loadData),
        .enable(enable),
        .count(count),
        .zero(zero),
        .borrow(borrow)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs, advance the model, queue its expectation, sample 1ns after the edge.
    task automatic applyStimulus(input logic rst, input logic ld, input logic [3:0] d, input logic en);
        @(negedge clk);
        resetN   = rst;
        load     = ld;
        loadData = d;
        enable   = en;
        if (!rst) begin
            mCount = 4'h0; mReload = 4'h0; mBorrow = 1'b0;
        end else if (ld) begin
            mCount = d; mReload = d; mBorrow = 1'b0;
        end else if (en) begin
            if (mCount == 4'h0) begin
                mCount  = AUTO ? mReload : 4'hF;
                mBorrow = 1'b1;
            end else begin
                mCount  = mCount - 4'h1;
                mBorrow = 1'b0;
            end
        end else begin
            mBorrow = 1'b0;
        end
        sbq.push_back({mCount, (mCount == 4'h0), mBorrow});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 4'h9, 1'b1);
            exp = sbq.pop_front();
            nCompared++;
            if ({count, zero, borrow} !== exp) begin
                nMismatched++;
                $display("[TB] FAIL reset_sb edge%0d: got %h/%b/%b want %h/%b/%b", i, count, zero, borrow, exp[5:2], exp[1], exp[0]);
            end
            nCompared++;
            if ({count, zero, borrow} !== {4'h0, 1'b1, 1'b0}) begin
                nMismatched++;
                $display("[TB] FAIL reset_const edge%0d: got %h/%b/%b want 0/1/0", i, count, zero, borrow);
            end
        end
    endtask

    task automatic test_load_decrement();
        logic [3:0] seq [4] = '{4'h3, 4'h2, 4'h1, 4'h0};
        for (int i = 0; i < 4; i++) begin
            if (i == 0) applyStimulus(1'b1, 1'b1, 4'h3, 1'b0);
            else        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
            exp = sbq.pop_front();
            nCompared++;
            if ({count, zero, borrow} !== exp || {count, zero, borrow} !== {seq[i], (seq[i] == 4'h0), 1'b0}) begin
                nMismatched++;
                $display("[TB] FAIL load_dec step%0d: got %h/%b/%b want %h/%b/0", i, count, zero, borrow, seq[i], (seq[i] == 4'h0));
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] first  = AUTO ? 4'h3 : 4'hF;
        logic [3:0] second = AUTO ? 4'h2 : 4'hE;
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        exp = sbq.pop_front();
        nCompared++;
        if ({count, zero, borrow} !== exp || {count, borrow} !== {first, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL wrap: got %h/%b/%b want %h/0/1", count, zero, borrow, first);
        end
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        exp = sbq.pop_front();
        nCompared++;
        if ({count, zero, borrow} !== exp || {count, borrow} !== {second, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL wrap_next: got %h/%b/%b want %h/0/0", count, zero, borrow, second);
        end
    endtask

    task automatic test_auto_reload();
        logic [3:0] seqA [9] = '{4'h1, 4'h0, 4'h2, 4'h1, 4'h0, 4'h2, 4'h1, 4'h0, 4'h2};
        logic [3:0] seqB [9] = '{4'h1, 4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9};
        logic [3:0] want;
        logic       wantB;
        applyStimulus(1'b1, 1'b1, 4'h2, 1'b0);
        exp = sbq.pop_front();
        nCompared++;
        if ({count, zero, borrow} !== exp) begin
            nMismatched++;
            $display("[TB] FAIL reload_load: got %h/%b/%b want %h/%b/%b", count, zero, borrow, exp[5:2], exp[1], exp[0]);
        end
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
            want  = AUTO ? seqA[i] : seqB[i];
            wantB = AUTO ? (seqA[i] == 4'h2) : (i == 2);
            exp = sbq.pop_front();
            nCompared++;
            if ({count, zero, borrow} !== exp || {count, borrow} !== {want, wantB}) begin
                nMismatched++;
                $display("[TB] FAIL reload_seq step%0d: got %h/%b/%b want %h/%b/%b", i, count, zero, borrow, want, (want == 4'h0), wantB);
            end
        end
    endtask

    task automatic test_priority_hold();
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        void'(sbq.pop_front());
        applyStimulus(1'b1, 1'b1, 4'h5, 1'b1);
        exp = sbq.pop_front();
        nCompared++;
        if ({count, zero, borrow} !== exp || {count, zero, borrow} !== {4'h5, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL priority: got %h/%b/%b want 5/0/0", count, zero, borrow);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'hA, 1'b0);
            exp = sbq.pop_front();
            nCompared++;
            if ({count, zero, borrow} !== exp || count !== 4'h5) begin
                nMismatched++;
                $display("[TB] FAIL hold%0d: got %h/%b/%b want 5/0/0", i, count, zero, borrow);
            end
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 1'b1, 4'h1, 1'b0);
        void'(sbq.pop_front());
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        // Then a reset landing while borrow is high must cancel it.
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp = sbq.pop_front();
            nCompared++;
            if (exp !== {4'h0, 1'b1, 1'b0} && i != 2) begin
                nMismatched++;
                $display("[TB] FAIL reset_mid_model%0d: model %h", i, exp);
            end
        end
        nCompared++;
        if ({count, zero, borrow} !== {4'h0, 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_in_borrow: got %h/%b/%b want 0/1/0", count, zero, borrow);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b0);
        void'(sbq.pop_front());
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
            exp = sbq.pop_front();
            nCompared++;
            if ({count, zero, borrow} !== exp) begin
                nMismatched++;
                $display("[TB] FAIL zero_reload%0d: got %h/%b/%b want %h/%b/%b", i, count, zero, borrow, exp[5:2], exp[1], exp[0]);
            end
        end
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            exp = sbq.pop_front();
            nCompared++;
            if ({count, zero, borrow} !== exp) begin
                nMismatched++;
                $display("[TB] FAIL random%0d: got %h/%b/%b want %h/%b/%b", i, count, zero, borrow, exp[5:2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        resetN = 1'b0; load = 1'b0; loadData = 4'h0; enable = 1'b0;
        mCount = 4'h0; mReload = 4'h0; mBorrow = 1'b0;
        test_reset();
        test_load_decrement();
        test_wrap();
        test_auto_reload();
        test_priority_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
